// File: rtl/lock_key_run_ctrl_if.sv
// Key-stream, run-request and ap_ctrl_hs core signals of lock_key_run_ctrl.
// slave = the controller, master = whatever drives key words, run and the core responses.
interface lock_key_run_ctrl_if #(
    parameter int KEY_WIDTH = 80,
    parameter int WORD_W    = 16
);
    logic [WORD_W-1:0]    key_word;
    logic                 key_valid;
    logic                 key_ready;
    logic                 run;
    logic [KEY_WIDTH-1:0] locking_key;
    logic                 key_loaded;
    logic                 core_ap_start;
    logic                 core_ap_done;
    logic                 core_ap_ready;
    logic [31:0]          core_ap_return;
    logic [31:0]          result;
    logic                 result_valid;
    logic [31:0]          cycle_count;
    logic                 timeout;
    logic                 run_err;
    logic                 busy;

    modport slave (
        input  key_word, key_valid, run, core_ap_done, core_ap_ready, core_ap_return,
        output key_ready, locking_key, key_loaded, core_ap_start, result, result_valid,
               cycle_count, timeout, run_err, busy
    );

    modport master (
        output key_word, key_valid, run, core_ap_done, core_ap_ready, core_ap_return,
        input  key_ready, locking_key, key_loaded, core_ap_start, result, result_valid,
               cycle_count, timeout, run_err, busy
    );
endinterface

// File: rtl/lock_key_run_ctrl.sv
// Assembles the locking key from a word stream, then runs the locked core via ap_ctrl_hs with a watchdog.
// Key words take effect one edge after acceptance; key_ready drops while a run is in flight (ARM/RUN/DONE).
module lock_key_run_ctrl #(
    parameter int KEY_WIDTH = 80,
    parameter int WORD_W    = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    lock_key_run_ctrl_if.slave bus
);
    localparam int NWORDS = (KEY_WIDTH + WORD_W - 1) / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PAD_W  = NWORDS * WORD_W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 loaded_q, loaded_d;
    logic [31:0]          result_q, result_d;
    logic [31:0]          count_q, count_d;
    logic                 timeout_q, timeout_d;
    logic                 run_err_q, run_err_d;

    logic                 key_rdy;
    logic                 word_acc;
    logic [PAD_W-1:0]     key_pad;
    logic [KEY_WIDTH-1:0] key_merged;
    logic [31:0]          count_inc;
    logic                 wd_hit;

    assign key_rdy   = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign word_acc  = bus.key_valid && key_rdy;
    assign count_inc = count_q + 32'd1;
    assign wd_hit    = (count_inc == 32'(TIMEOUT));

    // The padded copy lets the last word overhang KEY_WIDTH; the overhang is simply dropped.
    always_comb begin
        key_pad = '0;
        key_pad[KEY_WIDTH-1:0] = key_q;
        key_pad[int'(idx_q) * WORD_W +: WORD_W] = bus.key_word;
        key_merged = key_pad[KEY_WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        key_d     = key_q;
        loaded_d  = loaded_q;
        result_d  = result_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        run_err_d = run_err_q;
        case (state_q)
            S_IDLE: begin
                if (word_acc) begin
                    key_d = key_merged;
                    if (bus.run) run_err_d = 1'b1;
                    if (NWORDS == 1) begin
                        loaded_d = 1'b1;
                    end else begin
                        loaded_d = 1'b0;
                        idx_d    = IDX_W'(1);
                        state_d  = S_LOAD;
                    end
                end else if (bus.run) begin
                    if (loaded_q) begin
                        count_d   = '0;
                        timeout_d = 1'b0;
                        run_err_d = 1'b0;
                        state_d   = S_ARM;
                    end else begin
                        run_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (bus.run) run_err_d = 1'b1;
                if (word_acc) begin
                    key_d = key_merged;
                    if (idx_q == IDX_W'(NWORDS - 1)) begin
                        loaded_d = 1'b1;
                        idx_d    = '0;
                        state_d  = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_ARM: begin
                count_d = count_inc;
                // Done beats the watchdog; the watchdog beats a ready-only handoff to RUN.
                if (bus.core_ap_ready && bus.core_ap_done) begin
                    result_d = bus.core_ap_return;
                    state_d  = S_DONE;
                end else if (wd_hit) begin
                    timeout_d = 1'b1;
                    result_d  = '0;
                    state_d   = S_DONE;
                end else if (bus.core_ap_ready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                count_d = count_inc;
                if (bus.core_ap_done) begin
                    result_d = bus.core_ap_return;
                    state_d  = S_DONE;
                end else if (wd_hit) begin
                    timeout_d = 1'b1;
                    result_d  = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            key_q     <= '0;
            loaded_q  <= 1'b0;
            result_q  <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
            run_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            loaded_q  <= loaded_d;
            result_q  <= result_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            run_err_q <= run_err_d;
        end
    end

    assign bus.key_ready     = key_rdy;
    assign bus.locking_key   = key_q;
    assign bus.key_loaded    = loaded_q;
    assign bus.core_ap_start = (state_q == S_ARM);
    assign bus.result        = result_q;
    assign bus.result_valid  = (state_q == S_DONE);
    assign bus.cycle_count   = count_q;
    assign bus.timeout       = timeout_q;
    assign bus.run_err       = run_err_q;
    assign bus.busy          = (state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_DONE);
endmodule

// File: tb/tb_lock_key_run_ctrl.sv
// Bench for lock_key_run_ctrl: directed scenarios plus random key/run/core traffic against a behavioural model.
module tb_lock_key_run_ctrl;
    localparam int KW = 80;
    localparam int WW = 16;
    localparam int NW = 5;
    localparam int TO = 16;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;

    lock_key_run_ctrl_if #(.KEY_WIDTH(KW), .WORD_W(WW)) bus();
    lock_key_run_ctrl_if #(.KEY_WIDTH(12), .WORD_W(8))  bus2();

    lock_key_run_ctrl #(.KEY_WIDTH(KW), .WORD_W(WW), .TIMEOUT(TO)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus)
    );
    lock_key_run_ctrl #(.KEY_WIDTH(12), .WORD_W(8), .TIMEOUT(8)) dut_narrow (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus2)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [WW-1:0] m_words [NW];
    int            m_got;
    bit            m_loaded, m_err, m_tmo, m_rv, m_fly, m_rdy_seen;
    logic [31:0]   m_result, m_count;

    function automatic logic [KW-1:0] m_key();
        logic [NW*WW-1:0] w;
        for (int i = 0; i < NW; i++) w[i*WW +: WW] = m_words[i];
        return w[KW-1:0];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NW; i++) m_words[i] = '0;
        m_got = 0; m_loaded = 0; m_err = 0; m_tmo = 0; m_rv = 0; m_fly = 0; m_rdy_seen = 0;
        m_result = '0; m_count = '0;
    endtask

    // Advance one clock edge using the inputs that edge will sample.
    task automatic m_step();
        if (m_rv) begin
            m_rv = 0;
        end else if (m_fly) begin
            m_count = m_count + 1;
            if (bus.core_ap_done && (m_rdy_seen || bus.core_ap_ready)) begin
                m_result = bus.core_ap_return; m_rv = 1; m_fly = 0;
            end else if (m_count == TO) begin
                m_tmo = 1; m_result = '0; m_rv = 1; m_fly = 0;
            end else if (bus.core_ap_ready) begin
                m_rdy_seen = 1;
            end
        end else if (bus.key_valid) begin
            m_words[m_got] = bus.key_word;
            if (bus.run) m_err = 1;
            m_loaded = 0;
            m_got++;
            if (m_got == NW) begin
                m_got = 0; m_loaded = 1;
            end
        end else if (bus.run) begin
            if (m_got != 0 || !m_loaded) m_err = 1;
            else begin
                m_fly = 1; m_rdy_seen = 0; m_count = '0; m_tmo = 0; m_err = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge ap_clk);
            if (ap_rst) m_reset();
            chk("key_ready",   bus.key_ready,     !(m_fly || m_rv));
            chk("locking_key", bus.locking_key,   m_key());
            chk("key_loaded",  bus.key_loaded,    m_loaded);
            chk("ap_start",    bus.core_ap_start, m_fly && !m_rdy_seen);
            chk("result",      bus.result,        m_result);
            chk("result_vld",  bus.result_valid,  m_rv);
            chk("cycle_count", bus.cycle_count,   m_count);
            chk("timeout",     bus.timeout,       m_tmo);
            chk("run_err",     bus.run_err,       m_err);
            chk("busy",        bus.busy,          m_fly || m_rv);
            if (!ap_rst) m_step();
        end
    end

    // ---------------- core model ----------------
    int          r_lat = 1, d_lat = 1;
    logic [31:0] ret_val = '0;
    bit          rand_core = 0;
    bit          c_running = 0;
    int          c_k = 0;

    initial begin
        bus.core_ap_ready = 1'b0; bus.core_ap_done = 1'b0; bus.core_ap_return = '0;
        forever begin
            tick();
            if (!c_running && bus.core_ap_start) begin
                c_running = 1; c_k = 1;
                if (rand_core) begin
                    r_lat   = $urandom_range(1, 6);
                    d_lat   = ($urandom_range(0, 5) == 0) ? 0 : r_lat + $urandom_range(0, 8);
                    ret_val = $urandom;
                end
            end else if (c_running) begin
                if (!bus.busy) c_running = 0;
                else c_k++;
            end
            bus.core_ap_ready  = c_running && (c_k == r_lat);
            bus.core_ap_done   = c_running && (d_lat != 0) && (c_k == d_lat);
            bus.core_ap_return = ret_val;
        end
    end

    // Issue one run and watch it for a fixed window; cycle 1 is the first cycle with ap_start high.
    task automatic do_run(output int rvs, output int st, output int rv_at);
        rvs = 0; st = 0; rv_at = 0;
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        chk("run_err_clear_on_arm", bus.run_err, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            if (bus.core_ap_start) st++;
            if (bus.result_valid) begin
                rvs++;
                if (rv_at == 0) rv_at = c;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int rvs, st, rv_at;
        bus.key_word = '0; bus.key_valid = 1'b0; bus.run = 1'b0;
        bus2.key_word = '0; bus2.key_valid = 1'b0; bus2.run = 1'b0;
        bus2.core_ap_done = 1'b0; bus2.core_ap_ready = 1'b0; bus2.core_ap_return = '0;
        ap_rst = 1'b1;
        #2;
        chk("rst_key_ready", bus.key_ready, 1'b1);
        chk("rst_key",       bus.locking_key, '0);
        chk("rst_start",     bus.core_ap_start, 1'b0);
        tick(); tick();
        ap_rst = 1'b0;

        // Narrow instance: last word overhangs KEY_WIDTH and untouched bits persist.
        bus2.key_valid = 1'b1; bus2.key_word = 8'hAB; tick();
        bus2.key_word = 8'hCD; tick();
        bus2.key_valid = 1'b0;
        chk("narrow_key_a", bus2.locking_key, 12'hDAB);
        chk("narrow_loaded_a", bus2.key_loaded, 1'b1);
        bus2.key_valid = 1'b1; bus2.key_word = 8'h11; tick();
        bus2.key_valid = 1'b0;
        chk("narrow_key_b", bus2.locking_key, 12'hD11);
        chk("narrow_loaded_b", bus2.key_loaded, 1'b0);
        bus2.key_valid = 1'b1; bus2.key_word = 8'h22; tick();
        bus2.key_valid = 1'b0;
        chk("narrow_key_c", bus2.locking_key, 12'h211);
        chk("narrow_loaded_c", bus2.key_loaded, 1'b1);

        // Run with no key loaded is rejected.
        bus.run = 1'b1; tick(); bus.run = 1'b0;
        chk("rejected_run_err", bus.run_err, 1'b1);
        chk("rejected_no_start", bus.core_ap_start, 1'b0);

        for (int i = 1; i <= 5; i++) begin
            bus.key_word = 16'(i); bus.key_valid = 1'b1;
            if (i == 5) chk("loaded_before_last", bus.key_loaded, 1'b0);
            tick();
        end
        bus.key_valid = 1'b0;
        chk("key_lit", bus.locking_key, 80'h0005_0004_0003_0002_0001);
        chk("key_loaded_lit", bus.key_loaded, 1'b1);

        r_lat = 10; d_lat = 10; ret_val = 32'h14;
        do_run(rvs, st, rv_at);
        chk("normal_rv_pulses", rvs, 1);
        chk("normal_result", bus.result, 32'h14);
        chk("normal_count", bus.cycle_count, 10);
        chk("normal_timeout", bus.timeout, 1'b0);
        chk("normal_rv_cycle", rv_at, 11);

        r_lat = 2; d_lat = 7; ret_val = 32'h7;
        do_run(rvs, st, rv_at);
        chk("rbd_start_cycles", st, 2);
        chk("rbd_result", bus.result, 32'h7);
        chk("rbd_count", bus.cycle_count, 7);
        chk("rbd_rv_pulses", rvs, 1);

        r_lat = 3; d_lat = 0; ret_val = 32'hDEAD;
        do_run(rvs, st, rv_at);
        chk("wd_timeout", bus.timeout, 1'b1);
        chk("wd_result", bus.result, 32'h0);
        chk("wd_count", bus.cycle_count, 16);
        chk("wd_rv_cycle", rv_at, 17);
        chk("wd_rv_pulses", rvs, 1);

        // Asynchronous reset in the middle of RUN.
        r_lat = 2; d_lat = 0;
        bus.run = 1'b1; tick(); bus.run = 1'b0;
        repeat (4) tick();
        chk("pre_rst_busy", bus.busy, 1'b1);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("arst_start", bus.core_ap_start, 1'b0);
        chk("arst_loaded", bus.key_loaded, 1'b0);
        chk("arst_key", bus.locking_key, '0);
        chk("arst_busy", bus.busy, 1'b0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        rvs = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.result_valid) rvs++;
            tick();
        end
        chk("arst_no_rv", rvs, 0);
        for (int i = 1; i <= 5; i++) begin
            bus.key_word = 16'(i * 16'h1111); bus.key_valid = 1'b1;
            tick();
        end
        bus.key_valid = 1'b0;
        chk("reload_key", bus.locking_key, 80'h5555_4444_3333_2222_1111);
        chk("reload_loaded", bus.key_loaded, 1'b1);

        rand_core = 1;
        for (int c = 0; c < 3000; c++) begin
            bus.key_valid = ($urandom_range(0, 2) == 0);
            bus.key_word  = 16'($urandom);
            bus.run       = ($urandom_range(0, 9) == 0);
            tick();
        end
        bus.key_valid = 1'b0; bus.run = 1'b0;
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
